// File: rtl/ym3438_reg_decode.sv
`default_nettype none
// ============================================================================
// Module      : ym3438_reg_decode
// Description : Register-write decoder behind the host I/O stage. Latches the
//               9-bit register address, holds the global registers
//               (0x21-0x2C) and turns data writes into single-cycle
//               registered strobes for the operator/channel register files.
//               It also keeps the shared frequency high-byte latches and
//               produces the key-on, timer-reset and DAC outputs.
// Ports       : MCLK/reset         - clock, synchronous active-high reset
//               write_addr_en      - address-write strobe, loads {bank,data}
//               write_data_en      - data-write strobe, decoded vs latched addr
//               data_bus, bank     - host byte and register bank
//               reg_21..reg_2c     - global register contents
//               dac_data, dac_en   - DAC byte and enable (0x2A / 0x2B[7])
//               timer_*_rst        - timer reset pulses from 0x27 writes
//               kon_*              - key-on strobe and fields
//               op_*               - operator register write strobe and fields
//               ch_wr, ch_reg      - channel register write strobe (0xB0-0xB6)
//               fnum_wr, fnum_ch3  - frequency write strobe (0xA0-0xAA)
//               wr_ch, wr_data     - channel index / payload for writes
// Revision    : 1.0 - initial release
// ============================================================================
module ym3438_reg_decode (
    input  logic        MCLK,
    input  logic        reset,
    input  logic        write_addr_en,
    input  logic        write_data_en,
    input  logic [7:0]  data_bus,
    input  logic        bank,
    output logic [7:0]  reg_21,
    output logic [3:0]  reg_22,
    output logic [7:0]  reg_24,
    output logic [1:0]  reg_25,
    output logic [7:0]  reg_26,
    output logic [7:0]  reg_27,
    output logic        timer_a_rst,
    output logic        timer_b_rst,
    output logic        kon_wr,
    output logic [2:0]  kon_ch,
    output logic [3:0]  kon_op,
    output logic [7:0]  dac_data,
    output logic        dac_en,
    output logic [4:0]  reg_2c,
    output logic        op_wr,
    output logic [2:0]  op_reg,
    output logic [2:0]  op_ch,
    output logic [1:0]  op_slot,
    output logic        ch_wr,
    output logic        ch_reg,
    output logic        fnum_wr,
    output logic        fnum_ch3,
    output logic [2:0]  wr_ch,
    output logic [13:0] wr_data
);

    logic [8:0] r_addr;
    logic [5:0] r_fnum_hi;
    logic [5:0] r_ch3_hi;

    // Decode always looks at the previously latched address, so a combined
    // address+data write hits the old register and retargets afterwards.
    logic [7:0] w_a;
    logic       w_bk;
    logic       w_not3;
    logic       w_glob;
    logic       w_kon;
    logic       w_op;
    logic       w_fnum_lo;
    logic       w_fnum_hi;
    logic       w_ch3_lo;
    logic       w_ch3_hi;
    logic       w_ch;
    logic [2:0] w_ch_idx;

    assign w_a       = r_addr[7:0];
    assign w_bk      = r_addr[8];
    assign w_not3    = (w_a[1:0] != 2'd3);
    assign w_glob    = write_data_en && !w_bk && (w_a[7:4] == 4'h2);
    // Key-on with channel field 3 is an invalid channel and is dropped.
    assign w_kon     = w_glob && (w_a[3:0] == 4'h8) && (data_bus[1:0] != 2'd3);
    assign w_op      = write_data_en && w_not3 && (w_a[7:4] >= 4'h3) && (w_a[7:4] <= 4'h9);
    assign w_fnum_lo = write_data_en && w_not3 && (w_a[7:2] == 6'h28);
    assign w_fnum_hi = write_data_en && w_not3 && (w_a[7:2] == 6'h29);
    assign w_ch3_lo  = write_data_en && w_not3 && (w_a[7:2] == 6'h2A);
    assign w_ch3_hi  = write_data_en && w_not3 && (w_a[7:2] == 6'h2B);
    assign w_ch      = write_data_en && w_not3 && (w_a[7:3] == 5'h16);
    // Bank 1 covers channels 3..5.
    assign w_ch_idx  = {1'b0, w_a[1:0]} + (w_bk ? 3'd3 : 3'd0);

    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_addr      <= 9'd0;
            r_fnum_hi   <= 6'd0;
            r_ch3_hi    <= 6'd0;
            reg_21      <= 8'd0;
            reg_22      <= 4'd0;
            reg_24      <= 8'd0;
            reg_25      <= 2'd0;
            reg_26      <= 8'd0;
            reg_27      <= 8'd0;
            dac_data    <= 8'd0;
            dac_en      <= 1'b0;
            reg_2c      <= 5'd0;
            timer_a_rst <= 1'b0;
            timer_b_rst <= 1'b0;
            kon_wr      <= 1'b0;
            kon_ch      <= 3'd0;
            kon_op      <= 4'd0;
            op_wr       <= 1'b0;
            op_reg      <= 3'd0;
            op_ch       <= 3'd0;
            op_slot     <= 2'd0;
            ch_wr       <= 1'b0;
            ch_reg      <= 1'b0;
            fnum_wr     <= 1'b0;
            fnum_ch3    <= 1'b0;
            wr_ch       <= 3'd0;
            wr_data     <= 14'd0;
        end else begin
            timer_a_rst <= 1'b0;
            timer_b_rst <= 1'b0;
            kon_wr      <= 1'b0;
            op_wr       <= 1'b0;
            ch_wr       <= 1'b0;
            fnum_wr     <= 1'b0;

            if (write_addr_en) begin
                r_addr <= {bank, data_bus};
            end

            if (w_glob) begin
                case (w_a[3:0])
                    4'h1: reg_21   <= data_bus;
                    4'h2: reg_22   <= data_bus[3:0];
                    4'h4: reg_24   <= data_bus;
                    4'h5: reg_25   <= data_bus[1:0];
                    4'h6: reg_26   <= data_bus;
                    4'h7: begin
                        reg_27      <= data_bus;
                        timer_a_rst <= data_bus[4];
                        timer_b_rst <= data_bus[5];
                    end
                    4'hA: dac_data <= data_bus;
                    4'hB: dac_en   <= data_bus[7];
                    4'hC: reg_2c   <= data_bus[7:3];
                    default: ;
                endcase
            end

            if (w_kon) begin
                kon_wr  <= 1'b1;
                kon_ch  <= {data_bus[2], data_bus[1:0]};
                kon_op  <= data_bus[7:4];
                wr_data <= {6'd0, data_bus};
            end

            if (w_op) begin
                op_wr   <= 1'b1;
                // 0x30 is group 0; wraps naturally through 0x9F -> 6.
                op_reg  <= w_a[6:4] - 3'd3;
                op_ch   <= w_ch_idx;
                op_slot <= w_a[3:2];
                wr_data <= {6'd0, data_bus};
            end

            // High-byte latches are shared by all channels and both banks.
            if (w_fnum_hi) begin
                r_fnum_hi <= data_bus[5:0];
            end
            if (w_ch3_hi) begin
                r_ch3_hi <= data_bus[5:0];
            end

            if (w_fnum_lo) begin
                fnum_wr  <= 1'b1;
                fnum_ch3 <= 1'b0;
                wr_ch    <= w_ch_idx;
                wr_data  <= {r_fnum_hi, data_bus};
            end

            // Channel-3 special mode: wr_ch carries the slot index, not a channel.
            if (w_ch3_lo) begin
                fnum_wr  <= 1'b1;
                fnum_ch3 <= 1'b1;
                wr_ch    <= {1'b0, w_a[1:0]};
                wr_data  <= {r_ch3_hi, data_bus};
            end

            if (w_ch) begin
                ch_wr   <= 1'b1;
                ch_reg  <= w_a[2];
                wr_ch   <= w_ch_idx;
                wr_data <= {6'd0, data_bus};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ym3438_reg_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_ym3438_reg_decode
// Description : Scoreboard bench for ym3438_reg_decode. Each data write pushes
//               the predicted strobe set and fields; the monitor pops one
//               entry per decoded write and checks idle cycles are quiet.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ym3438_reg_decode;

    logic        MCLK = 1'b0;
    logic        reset;
    logic        write_addr_en;
    logic        write_data_en;
    logic [7:0]  data_bus;
    logic        bank;
    logic [7:0]  reg_21;
    logic [3:0]  reg_22;
    logic [7:0]  reg_24;
    logic [1:0]  reg_25;
    logic [7:0]  reg_26;
    logic [7:0]  reg_27;
    logic        timer_a_rst;
    logic        timer_b_rst;
    logic        kon_wr;
    logic [2:0]  kon_ch;
    logic [3:0]  kon_op;
    logic [7:0]  dac_data;
    logic        dac_en;
    logic [4:0]  reg_2c;
    logic        op_wr;
    logic [2:0]  op_reg;
    logic [2:0]  op_ch;
    logic [1:0]  op_slot;
    logic        ch_wr;
    logic        ch_reg;
    logic        fnum_wr;
    logic        fnum_ch3;
    logic [2:0]  wr_ch;
    logic [13:0] wr_data;

    ym3438_reg_decode dut (
        .MCLK(MCLK), .reset(reset), .write_addr_en(write_addr_en),
        .write_data_en(write_data_en), .data_bus(data_bus), .bank(bank),
        .reg_21(reg_21), .reg_22(reg_22), .reg_24(reg_24), .reg_25(reg_25),
        .reg_26(reg_26), .reg_27(reg_27), .timer_a_rst(timer_a_rst),
        .timer_b_rst(timer_b_rst), .kon_wr(kon_wr), .kon_ch(kon_ch),
        .kon_op(kon_op), .dac_data(dac_data), .dac_en(dac_en), .reg_2c(reg_2c),
        .op_wr(op_wr), .op_reg(op_reg), .op_ch(op_ch), .op_slot(op_slot),
        .ch_wr(ch_wr), .ch_reg(ch_reg), .fnum_wr(fnum_wr), .fnum_ch3(fnum_ch3),
        .wr_ch(wr_ch), .wr_data(wr_data)
    );

    always #5 MCLK = ~MCLK;

    // strb order: {timer_a_rst, timer_b_rst, kon_wr, op_wr, ch_wr, fnum_wr}
    typedef struct packed {
        logic [5:0]  strb;
        logic [2:0]  kch;
        logic [3:0]  kop;
        logic [2:0]  oreg;
        logic [2:0]  och;
        logic [1:0]  oslot;
        logic        creg;
        logic        c3;
        logic [2:0]  wch;
        logic [13:0] wd;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    logic wd_seen = 1'b0;

    // Reference state
    logic [8:0] m_addr;
    logic [5:0] m_hi, m_c3;
    logic [7:0] m21, m24, m26, m27, mdac;
    logic [3:0] m22;
    logic [1:0] m25;
    logic       mdacen;
    logic [4:0] m2c;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 9'd0; m_hi = 6'd0; m_c3 = 6'd0;
        m21 = 8'd0; m22 = 4'd0; m24 = 8'd0; m25 = 2'd0; m26 = 8'd0;
        m27 = 8'd0; mdac = 8'd0; mdacen = 1'b0; m2c = 5'd0;
    endtask

    task automatic predict(input logic [7:0] d, output exp_t e);
        logic [7:0] a;
        logic       bk;
        int         chn;
        a   = m_addr[7:0];
        bk  = m_addr[8];
        chn = int'(a[1:0]) + (bk ? 3 : 0);
        e   = '0;
        if (!bk) begin
            case (a)
                8'h21: m21 = d;
                8'h22: m22 = d[3:0];
                8'h24: m24 = d;
                8'h25: m25 = d[1:0];
                8'h26: m26 = d;
                8'h27: begin m27 = d; e.strb[5] = d[4]; e.strb[4] = d[5]; end
                8'h28: if (d[1:0] != 2'd3) begin
                    e.strb[3] = 1'b1; e.kch = d[2:0]; e.kop = d[7:4];
                end
                8'h2A: mdac = d;
                8'h2B: mdacen = d[7];
                8'h2C: m2c = d[7:3];
                default: ;
            endcase
        end
        if (a >= 8'h30 && a <= 8'h9F && a[1:0] != 2'd3) begin
            e.strb[2] = 1'b1;
            e.oreg  = 3'((a / 16) - 3);
            e.och   = 3'(chn);
            e.oslot = a[3:2];
            e.wd    = {6'd0, d};
        end else if (a >= 8'hA4 && a <= 8'hA6) begin
            m_hi = d[5:0];
        end else if (a >= 8'hAC && a <= 8'hAE) begin
            m_c3 = d[5:0];
        end else if (a >= 8'hA0 && a <= 8'hA2) begin
            e.strb[0] = 1'b1; e.c3 = 1'b0; e.wch = 3'(chn); e.wd = {m_hi, d};
        end else if (a >= 8'hA8 && a <= 8'hAA) begin
            e.strb[0] = 1'b1; e.c3 = 1'b1; e.wch = {1'b0, a[1:0]}; e.wd = {m_c3, d};
        end else if (a >= 8'hB0 && a <= 8'hB6 && a != 8'hB3) begin
            e.strb[1] = 1'b1; e.creg = a[2]; e.wch = 3'(chn); e.wd = {6'd0, d};
        end
    endtask

    task automatic drive(input logic ae, input logic de, input logic rs,
                         input logic b, input logic [7:0] d);
        exp_t e;
        @(negedge MCLK);
        write_addr_en = ae; write_data_en = de; reset = rs; bank = b; data_bus = d;
        if (rs) begin
            model_reset();
        end else begin
            if (de) begin
                predict(d, e);
                sb.push_back(e);
            end
            if (ae) m_addr = {b, d};
        end
    endtask

    task automatic idle();
        @(negedge MCLK);
        write_addr_en = 1'b0; write_data_en = 1'b0; reset = 1'b0;
    endtask

    task automatic chk_globals();
        chk("reg_21", reg_21, m21);   chk("reg_22", reg_22, m22);
        chk("reg_24", reg_24, m24);   chk("reg_25", reg_25, m25);
        chk("reg_26", reg_26, m26);   chk("reg_27", reg_27, m27);
        chk("dac_data", dac_data, mdac); chk("dac_en", dac_en, mdacen);
        chk("reg_2c", reg_2c, m2c);
    endtask

    always @(posedge MCLK) wd_seen <= write_data_en && !reset;

    always @(negedge MCLK) begin
        exp_t       e;
        logic [5:0] act;
        act = {timer_a_rst, timer_b_rst, kon_wr, op_wr, ch_wr, fnum_wr};
        if (wd_seen) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("strobes", act, e.strb);
                if (e.strb[3]) begin
                    chk("kon_ch", kon_ch, e.kch);
                    chk("kon_op", kon_op, e.kop);
                end
                if (e.strb[2]) begin
                    chk("op_fields", {op_reg, op_ch, op_slot}, {e.oreg, e.och, e.oslot});
                    chk("op_data", wr_data, e.wd);
                end
                if (e.strb[1]) begin
                    chk("ch_fields", {ch_reg, wr_ch}, {e.creg, e.wch});
                    chk("ch_data", wr_data, e.wd);
                end
                if (e.strb[0]) begin
                    chk("fnum_fields", {fnum_ch3, wr_ch}, {e.c3, e.wch});
                    chk("fnum_data", wr_data, e.wd);
                end
            end
        end else begin
            chk("idle_strobes", act, 0);
        end
    end

    initial begin
        logic [7:0] ra;
        reset = 1'b1; write_addr_en = 1'b0; write_data_en = 1'b0;
        bank = 1'b0; data_bus = 8'd0;
        model_reset();
        repeat (3) @(negedge MCLK);
        chk("reset_outs", {reg_21, reg_22, reg_24, reg_25, reg_26, reg_27, dac_data,
                           dac_en, reg_2c, kon_ch, kon_op, op_reg, op_ch, op_slot},
            0);
        chk("reset_payload", {ch_reg, fnum_ch3, wr_ch, wr_data}, 0);
        idle();

        // Global write, then the same write from bank 1 is ignored
        drive(1, 0, 0, 0, 8'h24); drive(0, 1, 0, 0, 8'hA5); idle();
        chk("reg_24_write", reg_24, 8'hA5);
        drive(1, 0, 0, 1, 8'h24); drive(0, 1, 0, 1, 8'h5A); idle();
        chk("reg_24_bank1", reg_24, 8'hA5);

        // Timer control
        drive(1, 0, 0, 0, 8'h27); drive(0, 1, 0, 0, 8'h35); idle();
        chk("tmr_pulses", {timer_a_rst, timer_b_rst}, 2'b11);
        chk("reg_27", reg_27, 8'h35);

        // Key-on, then invalid channel 3
        drive(1, 0, 0, 0, 8'h28); drive(0, 1, 0, 0, 8'hF6); idle();
        chk("kon_f6", {kon_wr, kon_ch, kon_op}, {1'b1, 3'd6, 4'hF});
        drive(0, 1, 0, 0, 8'hF3); idle();
        chk("kon_f3", kon_wr, 0);

        // Frequency high latch then low write, latch retained
        drive(1, 0, 0, 1, 8'hA5); drive(0, 1, 0, 1, 8'h2B);
        drive(1, 0, 0, 1, 8'hA1); drive(0, 1, 0, 1, 8'h44); idle();
        chk("fnum_a1", {fnum_wr, fnum_ch3, wr_ch, wr_data}, {1'b1, 1'b0, 3'd4, 14'h2B44});
        drive(0, 1, 0, 1, 8'h10); idle();
        chk("fnum_keep", wr_data, 14'h2B10);

        // Channel-3 special frequency path
        drive(1, 0, 0, 1, 8'hAD); drive(0, 1, 0, 1, 8'h3F);
        drive(1, 0, 0, 1, 8'hAA); drive(0, 1, 0, 1, 8'h01); idle();
        chk("ch3_fnum", {fnum_wr, fnum_ch3, wr_ch, wr_data}, {1'b1, 1'b1, 3'd2, 14'h3F01});

        // Operator write and ignored slot-3 address
        drive(1, 0, 0, 0, 8'h7E); drive(0, 1, 0, 0, 8'h1F); idle();
        chk("op_7e", {op_wr, op_reg, op_slot, op_ch}, {1'b1, 3'd4, 2'd3, 3'd2});
        drive(1, 0, 0, 0, 8'h7F); drive(0, 1, 0, 0, 8'h1F); idle();
        chk("op_7f", op_wr, 0);

        // Combined address+data write uses the old address; then back-to-back
        drive(1, 0, 0, 0, 8'h21); drive(1, 1, 0, 0, 8'h31);
        drive(0, 1, 0, 0, 8'h77); drive(0, 1, 0, 0, 8'h78); idle();
        chk("reg_21_combo", reg_21, 8'h31);

        // Reset in the same cycle as a data write
        drive(1, 0, 0, 0, 8'h22); idle();
        drive(0, 1, 1, 0, 8'h0F); idle();
        chk("reg_22_reset", reg_22, 4'd0);
        chk_globals();

        // Randomised traffic
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(8'h20, 8'hBF));
            drive(1, 0, 0, 1'($urandom_range(0, 1)), ra);
            drive(0, 1, 0, 1'($urandom_range(0, 1)), 8'($urandom));
            if ($urandom_range(0, 1) == 1)
                drive(1'($urandom_range(0, 1)), 1, 0, 1'($urandom_range(0, 1)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle(); idle();
        chk_globals();
        chk("sb_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
